// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential right shifter.
// Holds the FSM state encoding, default sizes and shift-kind encodings.
package shifter_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int SHAMT_W_DEF = 5;

   localparam logic SHIFT_LOGICAL = 1'b0;
   localparam logic SHIFT_ARITH   = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational right-shift step of 0..STEP bits with a fill bit.
// Ports: data_i operand, k_i shift count, fill_i vacated-bit value,
//        data_o shifted result.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int STEP  = 1,
   parameter int KW    = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [KW-1:0]    k_i,
   input  logic             fill_i,
   output logic [WIDTH-1:0] data_o
);

   // Bit i takes bit i+k of the operand, or the fill bit once
   // that index runs off the top.
   always_comb begin
      data_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i + int'(k_i) < WIDTH) begin
            data_o[i] = data_i[i + int'(k_i)];
         end else begin
            data_o[i] = fill_i;
         end
      end
   end

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle SRL/SRA unit shifting up to STEP bits per clock.
// Ports: clk, rst (sync, active high), start/in/shamt/arith request,
//        busy while shifting, done one-cycle pulse, out result register.
module seq_right_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF,
   parameter int STEP    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               arith,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   out
);

   localparam int KW = $clog2(STEP + 1);

   state_e             state_q;
   logic [WIDTH-1:0]   data_q;
   logic [WIDTH-1:0]   data_d;
   logic [SHAMT_W-1:0] cnt_q;
   logic [SHAMT_W-1:0] cnt_d;
   logic               sign_q;
   logic [WIDTH-1:0]   out_q;
   logic               busy_q;
   logic               done_q;
   logic [KW-1:0]      k;
   logic               last;

   // k = min(STEP, cnt)
   always_comb begin
      if (int'(cnt_q) < STEP) begin
         k = KW'(cnt_q);
      end else begin
         k = KW'(STEP);
      end
   end

   assign cnt_d = cnt_q - SHAMT_W'(k);
   assign last  = (int'(cnt_q) <= STEP);

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .KW    (KW)
   ) u_step (
      .data_i (data_q),
      .k_i    (k),
      .fill_i (sign_q),
      .data_o (data_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  data_q <= in;
                  cnt_q  <= shamt;
                  sign_q <= arith & in[WIDTH-1];
                  if (shamt != '0) begin
                     state_q <= SHIFT;
                     busy_q  <= 1'b1;
                  end else begin
                     // Zero shift: result is the operand itself.
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     out_q   <= in;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               data_q <= data_d;
               cnt_q  <= cnt_d;
               if (last) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  out_q   <= data_d;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign out  = out_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter with STEP=1 and STEP=4 instances.
// Table vectors plus hand sequences for reset, handshake and back-to-back.
module tb_seq_right_shifter;
   import shifter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        start4;
   logic [31:0] in_v;
   logic [4:0]  shamt;
   logic        arith;
   logic        busy, done, busy4, done4;
   logic [31:0] out_v, out4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_right_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut (
      .clk(clk), .rst(rst), .start(start), .in(in_v), .shamt(shamt),
      .arith(arith), .busy(busy), .done(done), .out(out_v)
   );

   seq_right_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .in(in_v), .shamt(shamt),
      .arith(arith), .busy(busy4), .done(done4), .out(out4)
   );

   typedef struct {
      logic [31:0] d;
      logic [4:0]  s;
      logic        a;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[9];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present a request, take the accepting edge, then scramble the
   // inputs so any use of the live ports shows up in the result.
   task automatic launch(bit sel, logic [31:0] d, logic [4:0] s, logic a);
      in_v  = d;
      shamt = s;
      arith = a;
      if (sel) start4 = 1'b1;
      else     start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      start4 = 1'b0;
      in_v   = ~d;
      shamt  = ~s;
      arith  = ~a;
   endtask

   task automatic wait_done(bit sel, logic [31:0] exp_out, int exp_lat,
                            string name);
      int lat = 1;
      while (!(sel ? done4 : done) && lat < 200) begin
         chk({name, "_busy"}, {31'b0, sel ? busy4 : busy}, 32'd1);
         @(posedge clk);
         #1;
         lat++;
      end
      chk({name, "_done"}, {31'b0, sel ? done4 : done}, 32'd1);
      chk({name, "_busy_at_done"}, {31'b0, sel ? busy4 : busy}, 32'd0);
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({name, "_out"}, sel ? out4 : out_v, exp_out);
   endtask

   task automatic after_done(bit sel, logic [31:0] exp_out, string name);
      @(posedge clk);
      #1;
      chk({name, "_pulse_end"}, {31'b0, sel ? done4 : done}, 32'd0);
      chk({name, "_held"}, sel ? out4 : out_v, exp_out);
   endtask

   initial begin
      int ndone;

      vt[0] = '{32'h80000000, 5'd4,  SHIFT_LOGICAL, 32'h08000000, 5};
      vt[1] = '{32'h80000000, 5'd31, SHIFT_ARITH,   32'hFFFFFFFF, 32};
      vt[2] = '{32'h80000000, 5'd31, SHIFT_LOGICAL, 32'h00000001, 32};
      vt[3] = '{32'h12345678, 5'd0,  SHIFT_LOGICAL, 32'h12345678, 1};
      vt[4] = '{32'h12345678, 5'd0,  SHIFT_ARITH,   32'h12345678, 1};
      vt[5] = '{32'hF0F0F0F0, 5'd8,  SHIFT_ARITH,   32'hFFF0F0F0, 9};
      vt[6] = '{32'h7FFF0000, 5'd16, SHIFT_ARITH,   32'h00007FFF, 17};
      vt[7] = '{32'hDEADBEEF, 5'd1,  SHIFT_LOGICAL, 32'h6F56DF77, 2};
      vt[8] = '{32'hDEADBEEF, 5'd1,  SHIFT_ARITH,   32'hEF56DF77, 2};

      rst    = 1'b1;
      start  = 1'b0;
      start4 = 1'b0;
      in_v   = '0;
      shamt  = '0;
      arith  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_out", out_v, 32'd0);
      chk("rst_out4", out4, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      foreach (vt[i]) begin
         launch(1'b0, vt[i].d, vt[i].s, vt[i].a);
         wait_done(1'b0, vt[i].exp, vt[i].lat, $sformatf("vec%0d", i));
         after_done(1'b0, vt[i].exp, $sformatf("vec%0d", i));
      end

      // start held during SHIFT must not restart or queue anything
      launch(1'b0, 32'h80000000, 5'd4, SHIFT_LOGICAL);
      start = 1'b1;
      in_v  = 32'hFFFFFFFF;
      shamt = 5'd1;
      arith = 1'b1;
      fork
         begin
            repeat (2) @(posedge clk);
            #2;
            start = 1'b0;
         end
      join_none
      wait_done(1'b0, 32'h08000000, 5, "ignore");
      after_done(1'b0, 32'h08000000, "ignore");

      // back-to-back: new request in the DONE cycle
      launch(1'b0, 32'hAAAA5555, 5'd3, SHIFT_LOGICAL);
      wait_done(1'b0, 32'h15554AAA, 4, "b2b_first");
      launch(1'b0, 32'h0000F000, 5'd8, SHIFT_LOGICAL);
      wait_done(1'b0, 32'h000000F0, 9, "b2b_second");
      after_done(1'b0, 32'h000000F0, "b2b_second");

      // STEP=4 instance
      launch(1'b1, 32'hF0000000, 5'd10, SHIFT_ARITH);
      wait_done(1'b1, 32'hFFFC0000, 4, "s4_a");
      after_done(1'b1, 32'hFFFC0000, "s4_a");
      launch(1'b1, 32'h80000000, 5'd31, SHIFT_LOGICAL);
      wait_done(1'b1, 32'h00000001, 9, "s4_b");
      launch(1'b1, 32'h80000000, 5'd4, SHIFT_ARITH);
      wait_done(1'b1, 32'hF8000000, 2, "s4_c");
      launch(1'b1, 32'h0F0F0000, 5'd0, SHIFT_ARITH);
      wait_done(1'b1, 32'h0F0F0000, 1, "s4_d");

      // reset in the middle of a long arithmetic shift
      launch(1'b0, 32'hFFFF0000, 5'd20, SHIFT_ARITH);
      repeat (3) @(posedge clk);
      #1;
      chk("rstmid_busy_before", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rstmid_busy", {31'b0, busy}, 32'd0);
      chk("rstmid_done", {31'b0, done}, 32'd0);
      chk("rstmid_out", out_v, 32'd0);
      rst   = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) ndone++;
      end
      chk("rstmid_no_done", 32'(ndone), 32'd0);
      chk("rstmid_out_after", out_v, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_right_shifter.md
Name: seq_right_shifter

Overview:
- Multi-cycle right-shift unit for the MIPS datapath; the opposite direction to the fixed left-by-2 branch-offset shifter.
- Executes SRL/SRA (and SRLV/SRAV via a register-sourced shamt) by shifting STEP bits per clock under a start/done handshake.
- Sits beside the ALU; the controller stalls the pipeline while busy is high and captures out when done pulses.

Parameters:
WIDTH, 32, data width in bits
SHAMT_W, 5, shift-amount width; must equal log2(WIDTH)
STEP, 1, maximum bits shifted per cycle; legal range 1..WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
in  input  WIDTH  operand, latched when start is accepted
shamt  input  SHAMT_W  shift amount 0..WIDTH-1, latched when start is accepted
arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); latched when start is accepted
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse; out is valid in that cycle
out  output  WIDTH  result register; held until the next accepted start

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, out=0, done=0, busy=0, internal count=0.
  - Reset overrides any operation in flight; the partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1: data_reg<=in, cnt<=shamt, sign<=arith & in[WIDTH-1].
  - Next state is SHIFT if shamt!=0, else DONE.
- SHIFT:
  - Each cycle: k = min(STEP, cnt); data_reg <= data_reg >> k, with the vacated top k bits filled with sign; cnt <= cnt-k.
  - When cnt<=STEP, next state is DONE.
  - start is ignored while in SHIFT (no queueing).
- DONE:
  - done=1 for exactly one cycle; out=data_reg.
  - start=1 in this same cycle is accepted exactly as in IDLE (back-to-back operation); otherwise next state is IDLE.
- Latency: done is asserted ceil(shamt/STEP)+1 cycles after the start edge.
  - shamt=0 -> 1 cycle.
  - STEP=1, shamt=31 -> 32 cycles.
- Width rules:
  - Shift amounts are unsigned.
  - Arithmetic fill replicates bit WIDTH-1 of the latched operand, not of the live in port.
  - No value exceeds WIDTH bits; no overflow flag.
- Input changes after acceptance (in/shamt/arith) have no effect on the running operation.
- busy and done are never high together.
- out changes only in the DONE cycle or on reset.

Decomposition:
- Package shifter_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - WIDTH/SHAMT_W default constants;
  - SHIFT_LOGICAL=0 and SHIFT_ARITH=1 encodings.
- Sub-module shift_step: combinational; inputs data, k (0..STEP), fill bit; output data>>k with fill. It is instantiated once in the SHIFT datapath.
- The FSM, counter and registers stay in seq_right_shifter.

Test Plan:
1. Reset mid-op: start in=0xFFFF0000, shamt=20, arith=1; assert rst on cycle 5 -> next cycle busy=0, done=0, out=0, state IDLE; no done pulse follows.
2. Logical: in=0x80000000, shamt=4, arith=0, STEP=1 -> busy for cycles 1-4, done on cycle 5, out=0x08000000.
3. Arithmetic: in=0x80000000, shamt=31, arith=1 -> done 32 cycles after start, out=0xFFFFFFFF. Same operands with arith=0 -> out=0x00000001.
4. Zero shift: in=0x12345678, shamt=0 -> done 1 cycle after start, out=0x12345678, busy never high.
5. Handshake:
   - start pulsed repeatedly during SHIFT is ignored; result matches the first request.
   - start with in=0x0000F000, shamt=8, arith=0 in the DONE cycle -> new op accepted; done again 9 cycles later with out=0x000000F0.
6. STEP=4 build: in=0xF0000000, shamt=10, arith=1 -> shifts of 4, 4, 2; done 4 cycles after start, out=0xFFFC0000.
